// File: rtl/janela_scan_ctrl.sv
// Window scan sequencer: walks every KxK window of a WxH image in raster order
// and issues one pixel read request per window element over a valid/ready stream.
module janela_scan_ctrl #(
  parameter int ADDR_W  = 17,
  parameter int DIM_W   = 9,
  parameter int MAX_WIN = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       janela_dim,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              win_first,
  output logic              win_last,
  output logic [DIM_W-1:0]  out_x,
  output logic [DIM_W-1:0]  out_y,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, FINISH} state_t;

  state_t            state;
  logic [3:0]        k_q, r, c;
  logic [DIM_W-1:0]  w_q, h_q, wx, wy;
  logic [ADDR_W-1:0] base_q, win_base, row_base;

  logic [3:0]        k_m1, r_n, c_n;
  logic [DIM_W-1:0]  k_ext, half, wx_n, wy_n;
  logic [ADDR_W-1:0] row_n, win_n;
  logic              legal, adv, last;
  logic              unused_dim;

  assign unused_dim = ^janela_dim[31:4];
  assign k_m1  = k_q - 4'd1;
  assign k_ext = DIM_W'(k_q);
  assign half  = DIM_W'(k_q >> 1);
  assign legal = k_q[0] && (k_q <= 4'(MAX_WIN)) && (k_ext <= w_q) && (k_ext <= h_q);
  assign adv   = rd_valid && rd_ready;

  // Next window position. win_base = base + wy*W, row_base = win_base + r*W,
  // both maintained by adding W so no multiplier is needed.
  always_comb begin
    r_n   = r;
    c_n   = c;
    wx_n  = wx;
    wy_n  = wy;
    row_n = row_base;
    win_n = win_base;
    last  = 1'b0;
    if (adv) begin
      if (c != k_m1) begin
        c_n = c + 4'd1;
      end else begin
        c_n = 4'd0;
        if (r != k_m1) begin
          r_n   = r + 4'd1;
          row_n = row_base + ADDR_W'(w_q);
        end else begin
          r_n = 4'd0;
          if (wx != w_q - k_ext) begin
            wx_n  = wx + DIM_W'(1);
            row_n = win_base;
          end else begin
            wx_n = '0;
            if (wy != h_q - k_ext) begin
              wy_n  = wy + DIM_W'(1);
              win_n = win_base + ADDR_W'(w_q);
              row_n = win_base + ADDR_W'(w_q);
            end else begin
              last = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      base_q    <= '0;
      r         <= '0;
      c         <= '0;
      wx        <= '0;
      wy        <= '0;
      row_base  <= '0;
      win_base  <= '0;
      rd_addr   <= '0;
      rd_valid  <= 1'b0;
      win_first <= 1'b0;
      win_last  <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            k_q     <= janela_dim[3:0];
            w_q     <= img_width;
            h_q     <= img_height;
            base_q  <= base_addr;
            cfg_err <= 1'b0;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (abort) begin
            state <= FINISH;
          end else if (!legal) begin
            cfg_err <= 1'b1;
            state   <= FINISH;
          end else begin
            r        <= '0;
            c        <= '0;
            wx       <= '0;
            wy       <= '0;
            row_base <= base_q;
            win_base <= base_q;
            state    <= SCAN;
          end
        end
        SCAN: begin
          // Abort wins over a same-cycle handshake; that transfer is dropped.
          if (abort || last) begin
            rd_valid <= 1'b0;
            state    <= FINISH;
          end else begin
            r         <= r_n;
            c         <= c_n;
            wx        <= wx_n;
            wy        <= wy_n;
            row_base  <= row_n;
            win_base  <= win_n;
            rd_valid  <= 1'b1;
            rd_addr   <= row_n + ADDR_W'(wx_n) + ADDR_W'(c_n);
            win_first <= (r_n == 4'd0) && (c_n == 4'd0);
            win_last  <= (r_n == k_m1) && (c_n == k_m1);
            out_x     <= wx_n + half;
            out_y     <= wy_n + half;
          end
        end
        FINISH: begin
          rd_valid <= 1'b0;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_janela_scan_ctrl.sv
// Randomized bench for janela_scan_ctrl; expected request stream comes from
// nested window loops over the image geometry.
module tb_janela_scan_ctrl;
  localparam int ADDR_W = 17;
  localparam int DIM_W  = 9;
  localparam int MAX_WIN = 7;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              first;
    logic              last;
    logic [DIM_W-1:0]  ox;
    logic [DIM_W-1:0]  oy;
  } exp_t;

  logic              clk, reset_n, start, abort, rd_ready;
  logic [31:0]       janela_dim;
  logic [DIM_W-1:0]  img_width, img_height;
  logic [ADDR_W-1:0] base_addr, rd_addr;
  logic              rd_valid, win_first, win_last, busy, done, cfg_err;
  logic [DIM_W-1:0]  out_x, out_y;

  int nchk = 0;
  int nerr = 0;

  janela_scan_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .MAX_WIN(MAX_WIN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .janela_dim(janela_dim), .img_width(img_width), .img_height(img_height),
    .base_addr(base_addr), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .win_first(win_first), .win_last(win_last), .out_x(out_x), .out_y(out_y),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_addr"}, rd_addr, 0);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_first"}, win_first, 0);
    chk({tag, "_last"}, win_last, 0);
    chk({tag, "_ox"}, out_x, 0);
    chk({tag, "_oy"}, out_y, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, cfg_err, 0);
  endtask

  task automatic run_scan(input int k, input int w, input int h, input int base,
                          input bit rnd, input int abort_n, input bit dup_start);
    exp_t q[$];
    exp_t e;
    bit legal, got_done, pv, pr, pa;
    int hs, cyc, last_hs, abort_cyc, first_v, total, exp_done;
    logic [ADDR_W-1:0] h_addr;
    logic h_first, h_last;
    logic [DIM_W-1:0] h_ox, h_oy;
    logic [31:0] jd;

    legal = (k % 2 == 1) && (k <= MAX_WIN) && (k <= w) && (k <= h);
    if (legal)
      for (int wy = 0; wy <= h - k; wy++)
        for (int wx = 0; wx <= w - k; wx++)
          for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++) begin
              e.addr  = ADDR_W'(base + (wy + r) * w + wx + c);
              e.first = (r == 0) && (c == 0);
              e.last  = (r == k - 1) && (c == k - 1);
              e.ox    = DIM_W'(wx + k / 2);
              e.oy    = DIM_W'(wy + k / 2);
              q.push_back(e);
            end
    total = q.size();

    @(negedge clk);
    jd = $urandom;
    jd[3:0] = 4'(k);
    janela_dim = jd;
    img_width  = DIM_W'(w);
    img_height = DIM_W'(h);
    base_addr  = ADDR_W'(base);
    start = 1'b1;
    abort = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    // configuration changes after the start must be ignored
    janela_dim = $urandom;
    img_width  = DIM_W'($urandom);
    img_height = DIM_W'($urandom);
    base_addr  = ADDR_W'($urandom);
    chk("busy_on", busy, 1);
    chk("cfg_err_clr", cfg_err, 0);
    chk("valid_setup", rd_valid, 0);

    hs = 0; cyc = 0; got_done = 0; pv = 0; pr = 0; pa = 0;
    last_hs = -10; abort_cyc = -10; first_v = -1;
    h_addr = '0; h_first = 0; h_last = 0; h_ox = '0; h_oy = '0;
    while (!got_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      abort = 1'b0;
      start = 1'b0;
      if (done) begin
        got_done = 1;
      end else begin
        chk("busy_run", busy, 1);
        if (!legal) chk("no_valid", rd_valid, 0);
        if (cyc == abort_cyc + 1) chk("abort_drop", rd_valid, 0);
        if (pv && !pr && !pa) begin
          chk("hold_valid", rd_valid, 1);
          chk("hold_addr", rd_addr, h_addr);
          chk("hold_first", win_first, h_first);
          chk("hold_last", win_last, h_last);
          chk("hold_ox", out_x, h_ox);
          chk("hold_oy", out_y, h_oy);
        end
        if (rd_valid && first_v < 0) first_v = cyc;
        rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (abort_n >= 0 && hs == abort_n && abort_cyc < 0 && rd_valid) begin
          abort = 1'b1;
          rd_ready = 1'b1;
          abort_cyc = cyc;
        end
        if (dup_start && cyc == 4) start = 1'b1;
        if (rd_valid && rd_ready && !abort) begin
          if (q.size() == 0) begin
            chk("extra_xfer", hs, total);
          end else begin
            e = q.pop_front();
            chk("addr", rd_addr, e.addr);
            chk("win_first", win_first, e.first);
            chk("win_last", win_last, e.last);
            chk("out_x", out_x, e.ox);
            chk("out_y", out_y, e.oy);
          end
          hs++;
          last_hs = cyc;
        end
        pv = rd_valid; pr = rd_ready; pa = abort;
        h_addr = rd_addr; h_first = win_first; h_last = win_last; h_ox = out_x; h_oy = out_y;
      end
    end
    rd_ready = 1'b0;
    chk("done_seen", got_done, 1);
    if (!legal)            exp_done = 2;
    else if (abort_n >= 0) exp_done = abort_cyc + 2;
    else                   exp_done = last_hs + 2;
    chk("done_cycle", cyc, exp_done);
    if (legal) chk("first_latency", first_v, 2);
    chk("xfer_count", hs, !legal ? 0 : (abort_n >= 0 ? abort_n : total));
    chk("busy_off", busy, 0);
    chk("valid_off", rd_valid, 0);
    chk("cfg_err", cfg_err, !legal);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("cfg_err_hold", cfg_err, !legal);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    janela_dim = 32'd3; img_width = 9'd4; img_height = 9'd4; base_addr = '0;
    start = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_reset_valid", rd_valid, 1);
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
  endtask

  initial begin
    int ks[8] = '{1, 3, 5, 7, 3, 2, 9, 0};
    int k, w, h, b;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
    janela_dim = '0; img_width = '0; img_height = '0; base_addr = '0;
    #1 chk_idle_outputs("reset");
    #20;
    @(negedge clk);
    reset_n = 1'b1;

    run_scan(3, 4, 4, 0, 0, -1, 1);
    run_scan(3, 4, 4, 0, 1, -1, 0);
    run_scan(2, 8, 8, 0, 0, -1, 0);
    run_scan(5, 4, 8, 0, 0, -1, 0);
    run_scan(9, 10, 10, 0, 0, -1, 0);
    run_scan(3, 4, 4, 0, 0, -1, 0);
    run_scan(1, 2, 2, 100, 1, -1, 0);
    run_scan(3, 5, 5, 0, 0, 10, 0);
    run_scan(3, 5, 5, 0, 1, -1, 0);
    mid_reset();
    run_scan(3, 4, 4, 0, 0, -1, 0);

    for (int i = 0; i < 10; i++) begin
      k = ks[$urandom_range(0, 7)];
      w = $urandom_range(1, 12);
      h = $urandom_range(1, 12);
      b = ($urandom_range(0, 1) == 1) ? (2**ADDR_W - 1 - $urandom_range(0, 20))
                                      : $urandom_range(0, 2**ADDR_W - 1);
      run_scan(k, w, h, b, 1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
